window_macc_unit: RTL
=====================

# window_macc_unit

Parametrised per-DSP convolution unit, successor to the per-DSP allocator tile. It latches an output-pixel centre, captures in-window image samples from the broadcast issue stream, and pairs them in order with filter weights through two circular buffers. It runs the MACC, then adds the bias, applies a leaky ReLU, saturates, and presents one result per centre over a valid/ready handshake. One instance sits beside each DSP in the convolution array.

## Interface
Parameters:
- DATA_W, 18, signed sample/weight/bias/result width
- COORD_W, 8, image coordinate width (unsigned)
- CNT_W, 13, filter_length and counter width
- BUF_AW, 9, per-buffer address width (depth 2^BUF_AW)
- ACC_W, 48, signed accumulator width
- FRAC_W, 8, product fraction bits dropped before bias add (arithmetic shift)
- LEAK_SHIFT, 3, negative-slope shift (slope = 2^-LEAK_SHIFT)

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-low reset
- center_x / center_y  in  COORD_W  centre position
- center_we  in  1  latch centre and config; honoured only in IDLE
- filter_halfsize  in  2  window half-width hs (0..3)
- filter_length  in  CNT_W  MACC count N = W*H*D
- filter_bias  in  DATA_W  signed bias
- img_valid / img_ready  in / out  1  image-stream handshake
- img_x / img_y  in  COORD_W  sample position
- img_data  in  DATA_W  sample value
- flt_valid / flt_ready  in / out  1  weight-stream handshake
- flt_data  in  DATA_W  weight value
- result_valid / result_ready  out / in  1  result handshake
- result_data  out  DATA_W  saturated, activated result
- busy  out  1  high in every state except IDLE

## Operation
- States: IDLE -> RUN (center_we) -> FINISH -> OUTPUT -> IDLE (result_valid && result_ready).
- center_we latches cx, cy, hs, N, bias; clears accumulator and counters. center_we outside IDLE is ignored.
- Window test: |img_x-cx| <= hs and |img_y-cy| <= hs, evaluated at COORD_W+1 bits signed. Edges are not wrapped: cx=0 with hs=2 accepts only x 0..2.
- Image ready: in RUN, img_ready = !img_full || !in_window. Out-of-window samples are accepted and dropped. In-window samples are pushed only while img_wr_cnt < N; in-window samples beyond N are dropped.
- Filter ready: flt_ready = RUN && !flt_full && flt_wr_cnt < N.
- Counters (CNT_W each): img_wr_cnt, flt_wr_cnt, mac_cnt. A buffer is full when wr_cnt - mac_cnt == 2^BUF_AW. Buffer addresses are the counter's low BUF_AW bits, so wrap is natural.
- MAC issue: a MAC issues when mac_cnt < min(img_wr_cnt, flt_wr_cnt, N). acc += sext(img)*sext(flt), wrapping at ACC_W.
- RUN -> FINISH: when mac_cnt == N and the MAC pipeline is empty.
- FINISH computes in order:
  - s = (acc >>> FRAC_W) + sext(bias)
  - if s < 0, s = s >>> LEAK_SHIFT
  - saturate s to [-2^(DATA_W-1), 2^(DATA_W-1)-1]
  - register the result in result_data
- N == 0: RUN exits immediately, and the result is the leaky/saturated bias.

## Timing
- Reset (rst=0 at an edge): state IDLE; result_valid=0, result_data=0, img_ready=0, flt_ready=0, busy=0; counters and acc cleared. This applies mid-operation too; a pending result is lost.
- Buffers have 1-cycle read latency. The MAC pipeline is issue -> read data -> product register -> accumulate, so accumulate lands 3 cycles after issue.
- Throughput: 1 MAC/cycle sustained.
- Latency: last MAC issue at cycle T -> accumulate T+3 -> FINISH T+4 -> result_valid at T+5.
- result_data and result_valid hold until result_ready. Transfer takes 1 cycle, and busy falls the cycle after transfer.
- A push and a MAC pop on the same buffer in the same cycle are both legal. Fullness uses the pre-edge counters, so no bypass is needed.
- center_we in the same cycle as the transfer is ignored; it is accepted only in IDLE.

## Structure
- Shared package conv_pkg holds:
  - the state enum {IDLE, RUN, FINISH, OUTPUT}
  - the sat_signed(value, width) function
  - the leaky-ReLU function
  - default widths matching the parameter defaults
- Sub-module wmu_ring_buffer: a 1-write, 1-read, 1-cycle-latency RAM of DATA_W x 2^BUF_AW, instantiated twice (image, filter). The top level owns all counters and full logic.

## Test plan
- cx=cy=10, hs=1, N=9, bias=0, weights all 1.0 (1<<FRAC_W): raster-stream a 20x20 image with data=x -> 9 in-window samples captured, result 90; out-of-window samples accepted with img_ready=1.
- N=4, sum of products negative = -64.0, bias=0, LEAK_SHIFT=3 -> result -8.0.
- Products exceeding 2^(DATA_W-1) after shift -> result_data = 0x1FFFF (DATA_W=18); large negative -> 0x20000.
- BUF_AW=2, N=16, weight stream stalled: img_ready drops on the 5th in-window sample; release weights -> all 16 MACs complete, correct sum, no sample lost or duplicated.
- N=0, bias=+5.0 -> result 5.0 at cycle center_we+3; hold result_ready=0 for 10 cycles -> result_valid and result_data stable; a center_we pulse during the hold is ignored.
- Assert rst=0 mid-RUN -> next cycle all outputs at reset values; a new center_we then yields a correct fresh result.

Source files
------------

// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared state encoding, default widths and arithmetic helpers for window_macc_unit
package conv_pkg;

  localparam int DEF_DATA_W     = 18;
  localparam int DEF_COORD_W    = 8;
  localparam int DEF_CNT_W      = 13;
  localparam int DEF_BUF_AW     = 9;
  localparam int DEF_ACC_W      = 48;
  localparam int DEF_FRAC_W     = 8;
  localparam int DEF_LEAK_SHIFT = 3;

  // Wide enough to hold the accumulator plus bias without overflow.
  localparam int WIDE_W = 64;
  typedef logic signed [WIDE_W-1:0] wide_t;

  typedef enum logic [1:0] {IDLE, RUN, FINISH, OUTPUT} state_t;

  function automatic wide_t sat_signed(input wide_t value, input int width);
    wide_t hi;
    wide_t lo;
    hi = (wide_t'(1) <<< (width - 1)) - wide_t'(1);
    lo = -(wide_t'(1) <<< (width - 1));
    if (value > hi) return hi;
    else if (value < lo) return lo;
    else return value;
  endfunction

  function automatic wide_t leaky_relu(input wide_t value, input int shift);
    if (value[WIDE_W-1]) return value >>> shift;
    else return value;
  endfunction

endpackage

// File: rtl/wmu_ring_buffer.sv
// rtl/wmu_ring_buffer.sv - 1W/1R sample store with registered read; addressing owned by the parent
module wmu_ring_buffer #(
  parameter int DATA_W = 18,
  parameter int BUF_AW = 9
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [BUF_AW-1:0]        wr_addr,
  input  logic signed [DATA_W-1:0] wr_data,
  input  logic                     rd_en,
  input  logic [BUF_AW-1:0]        rd_addr,
  output logic signed [DATA_W-1:0] rd_data
);

  logic signed [DATA_W-1:0] mem [2**BUF_AW];

  // Push and pop never share an address: that would need the buffer empty or full.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/window_macc_unit.sv
// rtl/window_macc_unit.sv - per-DSP windowed MACC: capture, pair with weights, bias, leaky ReLU, saturate
module window_macc_unit
  import conv_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int COORD_W    = DEF_COORD_W,
  parameter int CNT_W      = DEF_CNT_W,
  parameter int BUF_AW     = DEF_BUF_AW,
  parameter int ACC_W      = DEF_ACC_W,
  parameter int FRAC_W     = DEF_FRAC_W,
  parameter int LEAK_SHIFT = DEF_LEAK_SHIFT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [COORD_W-1:0]       center_x,
  input  logic [COORD_W-1:0]       center_y,
  input  logic                     center_we,
  input  logic [1:0]               filter_halfsize,
  input  logic [CNT_W-1:0]         filter_length,
  input  logic signed [DATA_W-1:0] filter_bias,
  input  logic                     img_valid,
  output logic                     img_ready,
  input  logic [COORD_W-1:0]       img_x,
  input  logic [COORD_W-1:0]       img_y,
  input  logic signed [DATA_W-1:0] img_data,
  input  logic                     flt_valid,
  output logic                     flt_ready,
  input  logic signed [DATA_W-1:0] flt_data,
  output logic                     result_valid,
  input  logic                     result_ready,
  output logic signed [DATA_W-1:0] result_data,
  output logic                     busy
);

  localparam logic [CNT_W-1:0] DEPTH = CNT_W'(2**BUF_AW);

  state_t                   state, state_nx;
  logic [COORD_W-1:0]       cx, cy;
  logic [1:0]               hs;
  logic [CNT_W-1:0]         n_len;
  logic signed [DATA_W-1:0] bias;
  logic [CNT_W-1:0]         img_wr_cnt, flt_wr_cnt, mac_cnt;
  logic signed [ACC_W-1:0]  acc;
  logic signed [2*DATA_W-1:0] prod;
  logic                     rd_vld, prod_vld;
  logic signed [DATA_W-1:0] img_rd, flt_rd;

  logic signed [COORD_W:0]  dx, dy;
  logic [COORD_W:0]         adx, ady;
  logic                     in_window, img_full, flt_full;
  logic                     img_push, flt_push, mac_issue, run_done;
  wide_t                    s_sum, s_act, s_sat;

  // Signed distance one bit wider than the coordinates so edges never wrap.
  assign dx  = $signed({1'b0, img_x}) - $signed({1'b0, cx});
  assign dy  = $signed({1'b0, img_y}) - $signed({1'b0, cy});
  assign adx = dx[COORD_W] ? -dx : dx;
  assign ady = dy[COORD_W] ? -dy : dy;
  assign in_window = (adx <= (COORD_W+1)'(hs)) && (ady <= (COORD_W+1)'(hs));

  assign img_full = (img_wr_cnt - mac_cnt) == DEPTH;
  assign flt_full = (flt_wr_cnt - mac_cnt) == DEPTH;

  assign img_ready = (state == RUN) && (!img_full || !in_window);
  assign flt_ready = (state == RUN) && !flt_full && (flt_wr_cnt < n_len);
  assign img_push  = img_valid && img_ready && in_window && (img_wr_cnt < n_len);
  assign flt_push  = flt_valid && flt_ready;

  assign mac_issue = (state == RUN) && (mac_cnt < img_wr_cnt) &&
                     (mac_cnt < flt_wr_cnt) && (mac_cnt < n_len);
  assign run_done  = (mac_cnt == n_len) && !mac_issue && !rd_vld && !prod_vld;

  assign result_valid = (state == OUTPUT);
  assign busy         = (state != IDLE);

  wmu_ring_buffer #(.DATA_W(DATA_W), .BUF_AW(BUF_AW)) u_img_buf (
    .clk     (clk),
    .wr_en   (img_push),
    .wr_addr (img_wr_cnt[BUF_AW-1:0]),
    .wr_data (img_data),
    .rd_en   (mac_issue),
    .rd_addr (mac_cnt[BUF_AW-1:0]),
    .rd_data (img_rd)
  );

  wmu_ring_buffer #(.DATA_W(DATA_W), .BUF_AW(BUF_AW)) u_flt_buf (
    .clk     (clk),
    .wr_en   (flt_push),
    .wr_addr (flt_wr_cnt[BUF_AW-1:0]),
    .wr_data (flt_data),
    .rd_en   (mac_issue),
    .rd_addr (mac_cnt[BUF_AW-1:0]),
    .rd_data (flt_rd)
  );

  always_comb begin
    s_sum = (wide_t'(acc) >>> FRAC_W) + wide_t'(bias);
    s_act = leaky_relu(s_sum, LEAK_SHIFT);
    s_sat = sat_signed(s_act, DATA_W);
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (center_we) state_nx = RUN;
      RUN:     if (run_done) state_nx = FINISH;
      FINISH:  state_nx = OUTPUT;
      OUTPUT:  if (result_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      cx          <= '0;
      cy          <= '0;
      hs          <= '0;
      n_len       <= '0;
      bias        <= '0;
      img_wr_cnt  <= '0;
      flt_wr_cnt  <= '0;
      mac_cnt     <= '0;
      acc         <= '0;
      prod        <= '0;
      rd_vld      <= 1'b0;
      prod_vld    <= 1'b0;
      result_data <= '0;
    end else begin
      state    <= state_nx;
      rd_vld   <= mac_issue;
      prod_vld <= rd_vld;
      if (rd_vld) prod <= (2*DATA_W)'(img_rd) * (2*DATA_W)'(flt_rd);
      if (state == IDLE && center_we) begin
        cx         <= center_x;
        cy         <= center_y;
        hs         <= filter_halfsize;
        n_len      <= filter_length;
        bias       <= filter_bias;
        img_wr_cnt <= '0;
        flt_wr_cnt <= '0;
        mac_cnt    <= '0;
        acc        <= '0;
      end else begin
        if (img_push)  img_wr_cnt <= img_wr_cnt + CNT_W'(1);
        if (flt_push)  flt_wr_cnt <= flt_wr_cnt + CNT_W'(1);
        if (mac_issue) mac_cnt    <= mac_cnt + CNT_W'(1);
        if (prod_vld)  acc        <= acc + ACC_W'(prod);
      end
      if (state == FINISH) result_data <= DATA_W'(s_sat);
    end
  end

endmodule
